// File: rtl/rggen_host_bus_adapter.sv
// rtl/rggen_host_bus_adapter.sv - host valid/ready request to rggen register bus bridge
// One transaction in flight; window decode, unmapped-address error and access watchdog.
module rggen_host_bus_adapter #(
  parameter int                           ADDRESS_WIDTH       = 8,
  parameter int                           LOCAL_ADDRESS_WIDTH = 8,
  parameter int                           BUS_WIDTH           = 32,
  parameter int                           REGISTERS           = 1,
  parameter logic [ADDRESS_WIDTH-1:0]     BASE_ADDRESS        = '0,
  parameter int                           TIMEOUT_CYCLES      = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_host_valid,
  output logic                             o_host_ready,
  input  logic                             i_host_write,
  input  logic [ADDRESS_WIDTH-1:0]         i_host_address,
  input  logic [BUS_WIDTH-1:0]             i_host_write_data,
  input  logic [BUS_WIDTH/8-1:0]           i_host_strobe,
  output logic                             o_resp_valid,
  input  logic                             i_resp_ready,
  output logic [BUS_WIDTH-1:0]             o_resp_read_data,
  output logic [1:0]                       o_resp_status,
  output logic                             o_register_valid,
  output logic [1:0]                       o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0]   o_register_address,
  output logic [BUS_WIDTH-1:0]             o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]           o_register_strobe,
  input  logic [REGISTERS-1:0]             i_register_active,
  input  logic [REGISTERS-1:0]             i_register_ready,
  input  logic [2*REGISTERS-1:0]           i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0]   i_register_read_data
);

  localparam int WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_WIDTH-1:0] LP_WD_LAST =
    WD_WIDTH'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic LP_WD_ENABLE = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] ST_OKAY   = 2'b00;
  localparam logic [1:0] ST_SLVERR = 2'b10;
  localparam logic [1:0] ST_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t               r_state;
  logic [WD_WIDTH-1:0]  r_wd_count;

  logic                 w_window_match;
  logic                 w_access_done;
  logic [1:0]           w_done_status;
  logic [BUS_WIDTH-1:0] w_done_data;
  logic [1:0]           w_ready_status;
  logic [BUS_WIDTH-1:0] w_active_data;

  generate
    if (ADDRESS_WIDTH > LOCAL_ADDRESS_WIDTH) begin : g_window
      assign w_window_match =
        (i_host_address[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH] ==
         BASE_ADDRESS[ADDRESS_WIDTH-1:LOCAL_ADDRESS_WIDTH]);
    end else begin : g_no_window
      assign w_window_match = 1'b1;
    end
  endgenerate

  // Status comes only from registers that finished; data from every register that hit.
  always_comb begin
    w_ready_status = '0;
    w_active_data  = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (i_register_ready[i]) begin
        w_ready_status = w_ready_status | i_register_status[2*i +: 2];
      end
      if (i_register_active[i]) begin
        w_active_data = w_active_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
      end
    end
  end

  always_comb begin
    w_access_done = 1'b0;
    w_done_status = ST_OKAY;
    w_done_data   = '0;
    if (!(|i_register_active)) begin
      w_access_done = 1'b1;
      w_done_status = ST_DECERR;
    end else if (|i_register_ready) begin
      w_access_done = 1'b1;
      w_done_status = w_ready_status;
      if (!o_register_access[0] && (w_ready_status == ST_OKAY)) begin
        w_done_data = w_active_data;
      end
    end else if (LP_WD_ENABLE && (r_wd_count == LP_WD_LAST)) begin
      w_access_done = 1'b1;
      w_done_status = ST_SLVERR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state               <= S_IDLE;
      r_wd_count            <= '0;
      o_host_ready          <= 1'b0;
      o_register_valid      <= 1'b0;
      o_register_access     <= 2'b10;
      o_register_address    <= '0;
      o_register_write_data <= '0;
      o_register_strobe     <= '0;
      o_resp_valid          <= 1'b0;
      o_resp_read_data      <= '0;
      o_resp_status         <= ST_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          o_host_ready <= 1'b1;
          if (i_host_valid && o_host_ready) begin
            o_host_ready <= 1'b0;
            if (w_window_match) begin
              r_state               <= S_ACCESS;
              r_wd_count            <= '0;
              o_register_valid      <= 1'b1;
              o_register_access     <= {1'b1, i_host_write};
              o_register_address    <= i_host_address[LOCAL_ADDRESS_WIDTH-1:0];
              o_register_write_data <= i_host_write_data;
              o_register_strobe     <= i_host_write ? i_host_strobe : '1;
            end else begin
              r_state          <= S_RESP;
              o_resp_valid     <= 1'b1;
              o_resp_status    <= ST_DECERR;
              o_resp_read_data <= '0;
            end
          end
        end
        S_ACCESS: begin
          o_host_ready <= 1'b0;
          if (w_access_done) begin
            r_state          <= S_RESP;
            o_register_valid <= 1'b0;
            o_resp_valid     <= 1'b1;
            o_resp_status    <= w_done_status;
            o_resp_read_data <= w_done_data;
          end else begin
            r_wd_count <= r_wd_count + 1'b1;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_state      <= S_IDLE;
            o_resp_valid <= 1'b0;
            o_host_ready <= 1'b1;
          end
        end
        default: begin
          r_state          <= S_IDLE;
          o_host_ready     <= 1'b0;
          o_register_valid <= 1'b0;
          o_resp_valid     <= 1'b0;
        end
      endcase
    end
  end

endmodule
